// File: rtl/pipearch_copy_pkg.sv
// pipearch_copy_pkg
// Shared types for the multi-channel copy operator:
//   t_copy_mode       - operating mode carried on cfg_mode
//   t_copymulti_state - operator FSM state, also exported for debug
//   ch_width()        - width of a channel index (at least 1 bit)
package pipearch_copy_pkg;

  typedef enum logic [1:0] {
    COPY_SINGLE     = 2'd0,
    COPY_INTERLEAVE = 2'd1,
    COPY_REPEAT     = 2'd2,
    COPY_RSVD       = 2'd3
  } t_copy_mode;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } t_copymulti_state;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipearch_copy_multi_if.sv
// pipearch_copy_multi_if
// Line-stream bundle between the read streams, the copy operator and the
// write stream.
//   rd_valid[NUM_CH], rd_data[NUM_CH][WIDTH], rd_ready[NUM_CH] : read side
//   wr_valid, wr_data[WIDTH], wr_ready                         : write side
// Handshake: a line moves on a rising clk edge where valid && ready are both
// high. A producer holding valid keeps its data stable until that edge; ready
// may depend combinationally on the consumer's own downstream ready.
// Modports: slave = the copy operator, master = the surrounding streams.
interface pipearch_copy_multi_if
  import pipearch_copy_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]            rd_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] rd_data;
  logic [NUM_CH-1:0]            rd_ready;
  logic                         wr_valid;
  logic [WIDTH-1:0]             wr_data;
  logic                         wr_ready;

  modport master (
    output rd_valid, rd_data, wr_ready,
    input  rd_ready, wr_valid, wr_data
  );

  modport slave (
    input  rd_valid, rd_data, wr_ready,
    output rd_ready, wr_valid, wr_data
  );
endinterface

// File: rtl/pipearch_copy_outreg.sv
// pipearch_copy_outreg
// Registered output line plus the per-line repeat counter.
//   clk, reset  : clock, synchronous active-high reset
//   load        : capture load_data (only asserted while out_free is high)
//   load_data   : next output line
//   wr_ready    : sink accepts the presented line
//   rep_lim     : extra writes per line (0 = each line written once)
//   out_free    : register may take a new line this cycle
//   wr_valid    : output line valid
//   wr_data     : output line
//   last_write  : this cycle's write handshake is the final copy of the line
module pipearch_copy_outreg
  import pipearch_copy_pkg::*;
#(
  parameter int WIDTH    = 512,
  parameter int REPEAT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_data,
  input  logic                wr_ready,
  input  logic [REPEAT_W-1:0] rep_lim,
  output logic                out_free,
  output logic                wr_valid,
  output logic [WIDTH-1:0]    wr_data,
  output logic                last_write
);

  logic [REPEAT_W-1:0] rep_cnt;
  logic                rep_end;

  assign rep_end    = (rep_cnt == rep_lim);
  // Free when empty, or when the final copy of the held line leaves this cycle,
  // which lets a new line follow with no bubble.
  assign out_free   = !wr_valid || (wr_ready && rep_end);
  assign last_write = wr_valid && wr_ready && rep_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid <= 1'b0;
      rep_cnt  <= '0;
    end else if (load) begin
      wr_valid <= 1'b1;
      rep_cnt  <= '0;
    end else if (wr_valid && wr_ready) begin
      if (!rep_end) rep_cnt <= rep_cnt + 1'b1;
      else          wr_valid <= 1'b0;
    end
  end

  // Data carries no reset: it is only meaningful while wr_valid is high.
  always_ff @(posedge clk) begin
    if (load) wr_data <= load_data;
  end

endmodule

// File: rtl/pipearch_copy_multi.sv
// pipearch_copy_multi
// Copies cfg_lines lines from one read stream (COPY), all streams in
// round-robin order (INTERLEAVE) or one stream with each line written
// cfg_repeat+1 times (REPEAT) into a single write stream.
//   clk, reset     : clock, synchronous active-high reset
//   op_start       : start pulse, honoured only in IDLE
//   cfg_lines      : lines to read; cfg_mode : t_copy_mode
//   cfg_src_sel    : source channel for COPY/REPEAT
//   cfg_repeat     : extra writes per line in REPEAT
//   bus            : read/write line streams (slave modport)
//   op_busy        : high while RUN
//   op_done        : one-cycle completion pulse
//   op_error       : pulses with op_done when the config was rejected
//   lines_written  : write handshakes of the current/last operation
//   state_dbg      : FSM state for debug
module pipearch_copy_multi
  import pipearch_copy_pkg::*;
#(
  parameter int WIDTH    = 512,
  parameter int NUM_CH   = 2,
  parameter int LINES_W  = 16,
  parameter int REPEAT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          op_start,
  input  logic [LINES_W-1:0]            cfg_lines,
  input  logic [1:0]                    cfg_mode,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_src_sel,
  input  logic [REPEAT_W-1:0]           cfg_repeat,
  pipearch_copy_multi_if.slave          bus,
  output logic                          op_busy,
  output logic                          op_done,
  output logic                          op_error,
  output logic [LINES_W+REPEAT_W-1:0]   lines_written,
  output t_copymulti_state              state_dbg
);

  localparam int              CH_W     = ch_width(NUM_CH);
  localparam logic [CH_W:0]   NUM_CH_X = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  t_copymulti_state               state, state_nx;
  t_copy_mode                     mode_q, start_mode;
  logic [LINES_W-1:0]             lines_q, rd_cnt;
  logic [REPEAT_W-1:0]            repeat_q, rep_lim;
  logic [CH_W-1:0]                cur_ch;
  logic                           err_q, start_bad;
  logic [LINES_W+REPEAT_W-1:0]    wr_cnt;
  logic                           rd_go, rd_fire, wr_fire;
  logic                           out_free, last_write, op_finish;

  assign start_mode = t_copy_mode'(cfg_mode);
  // The source select only matters for the single-source modes.
  assign start_bad  = (start_mode == COPY_RSVD) ||
                      ((start_mode != COPY_INTERLEAVE) && ({1'b0, cfg_src_sel} >= NUM_CH_X));

  assign rep_lim   = (mode_q == COPY_REPEAT) ? repeat_q : '0;
  assign rd_go     = (state == RUN) && out_free && (rd_cnt < lines_q);
  assign rd_fire   = rd_go && bus.rd_valid[cur_ch];
  assign wr_fire   = bus.wr_valid && bus.wr_ready;
  // Once every line has been read, the final copy leaving the register ends the op.
  assign op_finish = (state == RUN) && last_write && (rd_cnt == lines_q);

  always_comb begin
    bus.rd_ready = '0;
    if (rd_go) bus.rd_ready[cur_ch] = 1'b1;
  end

  pipearch_copy_outreg #(
    .WIDTH    (WIDTH),
    .REPEAT_W (REPEAT_W)
  ) u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (rd_fire),
    .load_data  (bus.rd_data[cur_ch]),
    .wr_ready   (bus.wr_ready),
    .rep_lim    (rep_lim),
    .out_free   (out_free),
    .wr_valid   (bus.wr_valid),
    .wr_data    (bus.wr_data),
    .last_write (last_write)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    op_busy  = 1'b0;
    op_done  = 1'b0;
    op_error = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_start) begin
          if (start_bad || (cfg_lines == '0)) state_nx = DONE;
          else                                state_nx = RUN;
        end
      end
      RUN: begin
        op_busy = 1'b1;
        if (op_finish) state_nx = DONE;
      end
      DONE: begin
        op_done  = 1'b1;
        op_error = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= COPY_SINGLE;
      lines_q  <= '0;
      repeat_q <= '0;
      err_q    <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      cur_ch   <= '0;
    end else if ((state == IDLE) && op_start) begin
      mode_q   <= start_mode;
      lines_q  <= cfg_lines;
      repeat_q <= cfg_repeat;
      err_q    <= start_bad;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      // A rejected config never reads, so park the channel pointer in range.
      cur_ch   <= ((start_mode == COPY_INTERLEAVE) || start_bad) ? '0 : cfg_src_sel;
    end else begin
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (mode_q == COPY_INTERLEAVE)
          cur_ch <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
      end
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign lines_written = wr_cnt;
  assign state_dbg     = state;

endmodule

// File: tb/tb_pipearch_copy_multi.sv
// tb_pipearch_copy_multi
// Directed bench for pipearch_copy_multi (WIDTH=64, NUM_CH=3). Each source
// channel presents line {ch, n} where n is that channel's pop count. Expected
// output lines are queued when an operation is issued; a negedge monitor pops
// and compares on every write handshake and checks that a stalled line holds.
module tb_pipearch_copy_multi;
  import pipearch_copy_pkg::*;

  localparam int WIDTH    = 64;
  localparam int NUM_CH   = 3;
  localparam int LINES_W  = 16;
  localparam int REPEAT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                        op_start;
  logic [LINES_W-1:0]          cfg_lines;
  logic [1:0]                  cfg_mode;
  logic [1:0]                  cfg_src_sel;
  logic [REPEAT_W-1:0]         cfg_repeat;
  logic                        op_busy, op_done, op_error;
  logic [LINES_W+REPEAT_W-1:0] lines_written;
  t_copymulti_state            state_dbg;

  pipearch_copy_multi_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  pipearch_copy_multi #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .LINES_W(LINES_W), .REPEAT_W(REPEAT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op_start      (op_start),
    .cfg_lines     (cfg_lines),
    .cfg_mode      (cfg_mode),
    .cfg_src_sel   (cfg_src_sel),
    .cfg_repeat    (cfg_repeat),
    .bus           (bus),
    .op_busy       (op_busy),
    .op_done       (op_done),
    .op_error      (op_error),
    .lines_written (lines_written),
    .state_dbg     (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops[NUM_CH];
  int ready_hi[NUM_CH];
  int wr_count = 0, done_count = 0, err_count = 0, busy_count = 0;
  int done_cyc = 0, err_cyc = 0, start_cyc = 0;
  int d0_done, d0_wr, d0_err, d0_busy;
  int valid_mode = 0;  // 0: all valid, 1: random
  int ready_mode = 0;  // 0: high, 1: toggle, 2: random, 3: low
  logic [WIDTH-1:0] exp_q[$];
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data;

  function automatic logic [WIDTH-1:0] mk(input int ch, input int idx);
    return {32'(ch), 32'(idx)};
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- source / sink driver ----------------
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.rd_data[c]  = mk(c, pops[c]);
      bus.rd_valid[c] = (valid_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    case (ready_mode)
      0:       bus.wr_ready = 1'b1;
      1:       bus.wr_ready = ~bus.wr_ready;
      2:       bus.wr_ready = 1'($urandom_range(0, 1));
      default: bus.wr_ready = 1'b0;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.rd_ready[c]) ready_hi[c]++;
        if (bus.rd_valid[c] && bus.rd_ready[c]) pops[c]++;
      end
      if (hold_pending) begin
        chk("hold_valid", 64'(bus.wr_valid), 64'(1));
        chk("hold_data", bus.wr_data, hold_data);
      end
      if (bus.wr_valid && bus.wr_ready) begin
        wr_count++;
        hold_pending = 1'b0;
        if (exp_q.size() == 0) chk("extra_write", bus.wr_data, 'x);
        else                   chk("wr_data", bus.wr_data, exp_q.pop_front());
      end else if (bus.wr_valid) begin
        hold_pending = 1'b1;
        hold_data    = bus.wr_data;
      end else begin
        hold_pending = 1'b0;
      end
      if (op_done)  begin done_count++; done_cyc = cyc; end
      if (op_error) begin err_count++;  err_cyc  = cyc; end
      if (op_busy)  busy_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [1:0] mode, input logic [1:0] src,
                          input int lines, input int rep);
    @(posedge clk); #1;
    for (int c = 0; c < NUM_CH; c++) begin
      pops[c]     = 0;
      ready_hi[c] = 0;
    end
    d0_done     = done_count;
    d0_wr       = wr_count;
    d0_err      = err_count;
    d0_busy     = busy_count;
    cfg_mode    = mode;
    cfg_src_sel = src;
    cfg_lines   = LINES_W'(lines);
    cfg_repeat  = REPEAT_W'(rep);
    op_start    = 1'b1;
    start_cyc   = cyc + 1;  // monitor cycle in which op_start is sampled
    @(posedge clk); #1;
    op_start    = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int t = 0;
    while (done_count == d0_done && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 64'(done_count - d0_done), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset       = 1'b1;
    op_start    = 1'b0;
    cfg_lines   = '0;
    cfg_mode    = 2'd0;
    cfg_src_sel = '0;
    cfg_repeat  = '0;
    bus.rd_valid = '0;
    bus.wr_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      pops[c] = 0;
      ready_hi[c] = 0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ready", 64'(bus.rd_ready), 64'(0));
    chk("rst_wr_valid", 64'(bus.wr_valid), 64'(0));
    chk("rst_busy", 64'(op_busy), 64'(0));
    chk("rst_done", 64'(op_done), 64'(0));
    chk("rst_error", 64'(op_error), 64'(0));
    chk("rst_lines_written", 64'(lines_written), 64'(0));
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;

    // COPY from ch1, 8 lines, no stalls: reads on S+1..S+8, writes S+2..S+9, done S+10.
    valid_mode = 0; ready_mode = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(1, i));
    start_op(2'd0, 2'd1, 8, 0);
    wait_done(100);
    chk("copy_done_cycle", 64'(done_cyc), 64'(start_cyc + 10));
    chk("copy_writes", 64'(wr_count - d0_wr), 64'(8));
    chk("copy_lines_written", 64'(lines_written), 64'(8));
    chk("copy_ch0_ready", 64'(ready_hi[0]), 64'(0));
    chk("copy_ch2_ready", 64'(ready_hi[2]), 64'(0));
    chk("copy_ch1_pops", 64'(pops[1]), 64'(8));
    chk("copy_busy_cycles", 64'(busy_count - d0_busy), 64'(9));
    chk("copy_no_error", 64'(err_count - d0_err), 64'(0));
    chk("copy_sb_empty", 64'(exp_q.size()), 64'(0));

    // INTERLEAVE, 7 lines: ch0,ch1,ch2,ch0,ch1,ch2,ch0.
    exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(2, 0));
    exp_q.push_back(mk(0, 1)); exp_q.push_back(mk(1, 1)); exp_q.push_back(mk(2, 1));
    exp_q.push_back(mk(0, 2));
    start_op(2'd1, 2'd0, 7, 0);
    wait_done(100);
    chk("ilv_done_cycle", 64'(done_cyc), 64'(start_cyc + 9));
    chk("ilv_pops0", 64'(pops[0]), 64'(3));
    chk("ilv_pops1", 64'(pops[1]), 64'(2));
    chk("ilv_pops2", 64'(pops[2]), 64'(2));
    chk("ilv_lines_written", 64'(lines_written), 64'(7));
    chk("ilv_sb_empty", 64'(exp_q.size()), 64'(0));

    // REPEAT x3 from ch0, 3 lines, sink toggling.
    ready_mode = 1;
    for (int i = 0; i < 3; i++)
      for (int r = 0; r < 3; r++) exp_q.push_back(mk(0, i));
    start_op(2'd2, 2'd0, 3, 2);
    wait_done(200);
    chk("rep_writes", 64'(wr_count - d0_wr), 64'(9));
    chk("rep_lines_written", 64'(lines_written), 64'(9));
    chk("rep_pops0", 64'(pops[0]), 64'(3));
    chk("rep_sb_empty", 64'(exp_q.size()), 64'(0));

    // Random source valid and sink ready, COPY from ch2, 1000 lines.
    valid_mode = 1; ready_mode = 2;
    for (int i = 0; i < 1000; i++) exp_q.push_back(mk(2, i));
    start_op(2'd0, 2'd2, 1000, 0);
    wait_done(20000);
    chk("rnd_writes", 64'(wr_count - d0_wr), 64'(1000));
    chk("rnd_lines_written", 64'(lines_written), 64'(1000));
    chk("rnd_sb_empty", 64'(exp_q.size()), 64'(0));
    valid_mode = 0; ready_mode = 0;

    // Zero lines: op_done the cycle after op_start is sampled, nothing read.
    start_op(2'd0, 2'd0, 0, 0);
    wait_done(20);
    chk("zero_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
    chk("zero_no_error", 64'(err_count - d0_err), 64'(0));
    chk("zero_ready", 64'(ready_hi[0] + ready_hi[1] + ready_hi[2]), 64'(0));
    chk("zero_lines_written", 64'(lines_written), 64'(0));

    // Reserved mode: done + error together, no transfers.
    start_op(2'd3, 2'd0, 5, 0);
    wait_done(20);
    chk("rsvd_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
    chk("rsvd_error", 64'(err_count - d0_err), 64'(1));
    chk("rsvd_error_with_done", 64'(err_cyc), 64'(done_cyc));
    chk("rsvd_writes", 64'(wr_count - d0_wr), 64'(0));

    // Source select out of range in COPY: rejected the same way.
    start_op(2'd0, 2'd3, 5, 0);
    wait_done(20);
    chk("badsrc_error", 64'(err_count - d0_err), 64'(1));
    chk("badsrc_error_with_done", 64'(err_cyc), 64'(done_cyc));
    chk("badsrc_ready", 64'(ready_hi[0] + ready_hi[1] + ready_hi[2]), 64'(0));
    chk("badsrc_lines_written", 64'(lines_written), 64'(0));

    // INTERLEAVE ignores the source select, so the same value is accepted.
    exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0));
    start_op(2'd1, 2'd3, 2, 0);
    wait_done(50);
    chk("ilvsrc_no_error", 64'(err_count - d0_err), 64'(0));
    chk("ilvsrc_lines_written", 64'(lines_written), 64'(2));
    chk("ilvsrc_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset while a line is stalled in the output register.
    ready_mode = 3;
    start_op(2'd0, 2'd0, 10, 0);
    for (int t = 0; t < 20 && !bus.wr_valid; t++) @(negedge clk);
    chk("mid_wr_valid_seen", 64'(bus.wr_valid), 64'(1));
    d0_done = done_count;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_valid", 64'(bus.wr_valid), 64'(0));
    chk("mid_rst_busy", 64'(op_busy), 64'(0));
    chk("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_count - d0_done), 64'(0));

    // Clean 4-line copy after the reset.
    ready_mode = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, i));
    start_op(2'd0, 2'd1, 4, 0);
    wait_done(100);
    chk("post_done_cycle", 64'(done_cyc), 64'(start_cyc + 6));
    chk("post_lines_written", 64'(lines_written), 64'(4));
    chk("post_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
